// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: FSM state encoding and internal BCD accumulator sizing.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Smallest n with 10^n >= 2^dw, i.e. ceil(dw*log10(2)); valid for dw <= 63
    function automatic int calc_int_digits(input int dw);
        longint unsigned p = 1;
        int n = 0;
        for (int i = 0; i < 20; i++)
            if (p < (64'd1 << dw)) begin
                p = p * 64'd10;
                n++;
            end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to any digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter, one bit per cycle.
// Optional zero-blanking output o_blank enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int DATAWIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [DATAWIDTH-1:0]  i_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_overflow
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     o_blank
`endif
);

    localparam int INT_DIGITS = calc_int_digits(DATAWIDTH);
    localparam int CW         = $clog2(DATAWIDTH + 1);

    state_t                  state, state_n;
    logic [CW-1:0]           cnt;
    logic [DATAWIDTH-1:0]    sreg;
    logic [4*INT_DIGITS-1:0] acc, adj;
    logic [4*DIGITS-1:0]     res;
    logic                    ovf;

    for (genvar i = 0; i < INT_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (.d(acc[4*i +: 4]), .q(adj[4*i +: 4]));
    end

    // Output digits are the low end of the accumulator; any higher digit means overflow
    if (INT_DIGITS > DIGITS) begin : g_ovf
        assign res = acc[4*DIGITS-1:0];
        assign ovf = |acc[4*INT_DIGITS-1:4*DIGITS];
    end else begin : g_fit
        assign res = (4*DIGITS)'(acc);
        assign ovf = 1'b0;
    end

    assign o_busy = (state == SHIFT);

    always_comb begin
        state_n = (state == IDLE)  ? (i_start ? SHIFT : IDLE) :
                  (state == SHIFT) ? ((cnt == CW'(1)) ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            sreg       <= '0;
            acc        <= '0;
            o_done     <= 1'b0;
            o_bcd      <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= (state == DONE);
            if (state == IDLE && i_start) begin
                sreg <= i_data;
                acc  <= '0;
                cnt  <= CW'(DATAWIDTH);
            end else if (state == SHIFT) begin
                {acc, sreg} <= {adj, sreg} << 1;
                cnt         <= cnt - CW'(1);
            end
            if (state == DONE) begin
                o_bcd      <= res;
                o_overflow <= ovf;
            end
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              z;

    // Bit k is set when digit k and everything above it are zero; ones digit never blanks
    always_comb begin
        blank = '0;
        z     = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            z        = z & (res[4*k +: 4] == 4'd0);
            blank[k] = z;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            o_blank <= '0;
        else if (state == DONE)
            o_blank <= blank;
    end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized check of bin2bcd_seq against an arithmetic decimal model.
module tb_bin2bcd_seq;

    localparam int DW = 14;
    localparam int DG = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_start;
    logic [DW-1:0]   i_data;
    logic            o_busy;
    logic            o_done;
    logic [4*DG-1:0] o_bcd;
    logic            o_overflow;
`ifdef BIN2BCD_BLANK_EN
    logic [DG-1:0]   o_blank;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bin2bcd_seq #(.DATAWIDTH(DW), .DIGITS(DG)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_data     (i_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_bcd      (o_bcd),
        .o_overflow (o_overflow)
`ifdef BIN2BCD_BLANK_EN
        ,
        .o_blank    (o_blank)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4*DG-1:0] to_bcd(input int v);
        logic [4*DG-1:0] r = '0;
        int x = v;
        for (int k = 0; k < DG; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [DG-1:0] to_blank(input int v);
        logic [DG-1:0] b = '0;
        for (int k = 1; k < DG; k++)
            b[k] = (v % (10 ** DG)) < (10 ** k);
        return b;
    endfunction

    // Model: m_t counts edges since the accepting edge, -1 when nothing is in flight
    int              m_t   = -1;
    int              m_val = 0;
    logic            m_done = 1'b0;
    logic [4*DG-1:0] m_bcd  = '0;
    logic            m_ovf  = 1'b0;
    logic [DG-1:0]   m_blank = '0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_t     = -1;
            m_bcd   = '0;
            m_ovf   = 1'b0;
            m_blank = '0;
        end else if ((m_t < 0 || m_t == DW + 1) && i_start) begin
            m_t   = 0;
            m_val = int'(i_data);
        end else if (m_t >= 0 && m_t <= DW) begin
            m_t++;
            if (m_t == DW + 1) begin
                m_done  = 1'b1;
                m_bcd   = to_bcd(m_val);
                m_ovf   = m_val >= 10 ** DG;
                m_blank = to_blank(m_val);
            end
        end else begin
            m_t = -1;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(o_busy), 32'(m_t >= 0 && m_t < DW));
        chk("done", 32'(o_done), 32'(m_done));
        chk("bcd", 32'(o_bcd), 32'(m_bcd));
        chk("ovf", 32'(o_overflow), 32'(m_ovf));
`ifdef BIN2BCD_BLANK_EN
        chk("blank", 32'(o_blank), 32'(m_blank));
`endif
    end

    task automatic go(input int v);
        i_data  = DW'(v);
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (!o_done && cyc < 200);
        chk("done_seen", 32'(o_done), 32'd1);
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(posedge clk);
            #1 if (o_done) c++;
        end
    endtask

    initial begin
        int cyc, c, sel;
        reset   = 1'b1;
        i_start = 1'b0;
        i_data  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_bcd", 32'(o_bcd), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);

        go(1234);
        wait_done(cyc);
        chk("lat_1234", cyc, 32'd15);
        chk("bcd_1234", 32'(o_bcd), 32'h1234);
        chk("ovf_1234", 32'(o_overflow), 32'd0);

        go(0);
        wait_done(cyc);
        chk("bcd_0", 32'(o_bcd), 32'h0000);
        chk("ovf_0", 32'(o_overflow), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        chk("blank_0", 32'(o_blank), 32'b1110);
`endif

        go(16383);
        wait_done(cyc);
        chk("bcd_max", 32'(o_bcd), 32'h6383);
        chk("ovf_max", 32'(o_overflow), 32'd1);
        go(9999);
        wait_done(cyc);
        chk("bcd_9999", 32'(o_bcd), 32'h9999);
        chk("ovf_9999", 32'(o_overflow), 32'd0);

        go(1234);
        repeat (4) @(posedge clk);
        #1 i_data = DW'(42);
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        count_done(25, c);
        chk("ignored_cnt", c, 32'd1);
        chk("ignored_bcd", 32'(o_bcd), 32'h1234);

        go(9999);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_bcd", 32'(o_bcd), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_ovf", 32'(o_overflow), 32'd0);
        count_done(20, c);
        chk("abort_cnt", c, 32'd0);
        go(7);
        wait_done(cyc);
        chk("lat_7", cyc, 32'd15);
        chk("bcd_7", 32'(o_bcd), 32'h0007);

        i_data  = DW'(500);
        i_start = 1'b1;
        wait_done(cyc);
        chk("bcd_500", 32'(o_bcd), 32'h0500);
        i_data = DW'(321);
        wait_done(cyc);
        chk("thru", cyc, 32'd16);
        chk("bcd_321", 32'(o_bcd), 32'h0321);
        i_start = 1'b0;
        count_done(20, c);

        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(0, 299) == 0);
            i_start = ($urandom_range(0, 3) == 0);
            sel     = int'($urandom_range(0, 7));
            i_data  = (sel == 0) ? DW'(9999) : (sel == 1) ? DW'(10000) :
                      (sel == 2) ? DW'(0) : (sel == 3) ? DW'(16383) : DW'($urandom);
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        i_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 14, binary input width (≥4).
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD output digits (≥1).
REQ-003 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  conversion request; sampled only in IDLE.
REQ-006 SHALL have port i_data  input  DATAWIDTH  unsigned binary value; captured on the accepted i_start.
REQ-007 SHALL have port o_busy  output  1  high while in SHIFT.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse when a result is written.
REQ-009 SHALL have port o_bcd  output  4*DIGITS  result; digit k at bits [4k+3:4k], digit 0 = ones.
REQ-010 SHALL have port o_overflow  output  1  high when the last result ≥ 10^DIGITS.

Function
REQ-011 SHALL implement iterative shift-add-3 (double dabble) with FSM states IDLE, SHIFT, DONE.
REQ-012 SHALL accept i_start in IDLE only: capture i_data, clear the internal BCD accumulator, load bit counter = DATAWIDTH, go to SHIFT.
REQ-013 In SHIFT, each cycle SHALL add 3 to every accumulator digit ≥5, then shift {accumulator, shift register} left by one bit, then decrement the counter.
REQ-014 SHALL move to DONE after exactly DATAWIDTH SHIFT cycles; in DONE, register o_bcd, o_overflow, pulse o_done for one cycle, return to IDLE.
REQ-015 Latency: o_done SHALL be high exactly DATAWIDTH+1 cycles after the clk edge that accepted i_start (14+1 = 15 at defaults).
REQ-016 i_start while in SHIFT or DONE SHALL be ignored; no queuing.
REQ-017 i_start held high continuously SHALL start a new conversion on the first IDLE cycle after o_done (throughput DATAWIDTH+2 cycles).
REQ-018 The internal accumulator SHALL have INT_DIGITS = ceil(DATAWIDTH·log10 2) digits, which is enough for 2^DATAWIDTH−1.
REQ-019 o_bcd SHALL be the low DIGITS digits of the accumulator (value mod 10^DIGITS).
REQ-020 o_overflow SHALL be 1 iff any accumulator digit above DIGITS−1 is nonzero; it SHALL be constant 0 when INT_DIGITS ≤ DIGITS.
REQ-021 o_bcd and o_overflow SHALL hold their value between o_done pulses, and SHALL NOT change during SHIFT.

Reset
REQ-022 reset SHALL force state IDLE; o_busy=0, o_done=0, o_bcd=0, o_overflow=0; counter, shift register and accumulator cleared.
REQ-023 reset asserted mid-conversion SHALL abort it with no o_done; reset takes priority over i_start in the same cycle.

Configuration
REQ-024 With macro BIN2BCD_BLANK_EN defined, SHALL add output o_blank [DIGITS-1:0], registered with o_bcd: bit k = 1 iff digit k and all higher output digits are 0, k≥1; bit 0 always 0; reset value 0.
REQ-025 Without BIN2BCD_BLANK_EN, o_blank and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 The shared package/include SHALL hold the FSM state encodings (IDLE, SHIFT, DONE) and the INT_DIGITS width calculation.
REQ-027 The per-digit "≥5 then add 3" correction SHALL be a sub-module bcd_add3 (4-bit in, 4-bit out, combinational), instantiated INT_DIGITS times.

Verification
REQ-028 Defaults, i_data=1234, i_start pulse -> o_done at cycle 15, o_bcd=0x1234, o_overflow=0.
REQ-029 i_data=0 -> o_bcd=0x0000, o_overflow=0; with BIN2BCD_BLANK_EN, o_blank=4'b1110.
REQ-030 i_data=16383 -> o_bcd=0x6383, o_overflow=1; next i_data=9999 -> o_bcd=0x9999, o_overflow=0.
REQ-031 Start 1234, pulse i_start with 42 at cycle 5 -> single o_done with 0x1234; no second o_done.
REQ-032 Start 9999, assert reset at cycle 7 -> no o_done; all outputs 0; new start with 7 -> o_bcd=0x0007 after 15 cycles.
REQ-033 DATAWIDTH=8, DIGITS=2, i_data=255 -> o_done at cycle 9, o_bcd=0x55, o_overflow=1; with blanking, i_data=7 -> o_blank=2'b10.
